// File: rtl/register_pipe_pkg.sv
// Shared constants and types for the register_pipe block.
// The optional occupancy counter is built only when REGISTER_PIPE_OCC_EN is defined.
package register_pipe_pkg;

    // Default build parameters
    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Legal parameter ranges, checked at elaboration by register_pipe
    localparam int MIN_WIDTH = 1;
    localparam int MAX_WIDTH = 64;
    localparam int MIN_DEPTH = 1;
    localparam int MAX_DEPTH = 16;

    // One pipeline stage at the default width: a valid flag travelling with its data word.
    // Bubbles keep their data; only the valid flag marks the word as meaningful.
    typedef struct packed {
        logic                     valid;
        logic [DEFAULT_WIDTH-1:0] data;
    } stage_t;

    // Bits needed to count 0..depth valid stages
    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/register_pipe_stage.sv
// pipe_stage: one {valid, data} register of the register_pipe shift chain.
// flush clears only the valid flag (data holds); rst clears both and wins over everything.
module pipe_stage
    import register_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state: flush drops the valid flag without shifting; en shifts both fields
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (en) begin
            valid_d = in_valid;
            data_d  = in_data;
        end
    end

    // Stage register with synchronous reset of both valid and data
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/register_pipe.sv
// register_pipe: DEPTH-stage enable-gated register pipeline carrying a valid bit per word.
// Q/out_valid come straight from the last stage flops, so there is no combinational path from D.
// Optional feature: define REGISTER_PIPE_OCC_EN to add the occ port (count of valid stages).
module register_pipe
    import register_pipe_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             D,
`ifdef REGISTER_PIPE_OCC_EN
    output logic [occ_width(DEPTH)-1:0]  occ,
`endif
    output logic                         out_valid,
    output logic [WIDTH-1:0]             Q
);

    // Parameter range checks
    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("register_pipe: WIDTH=%0d outside %0d..%0d", WIDTH, MIN_WIDTH, MAX_WIDTH);
        end
        if (DEPTH < MIN_DEPTH || DEPTH > MAX_DEPTH) begin : g_bad_depth
            $error("register_pipe: DEPTH=%0d outside %0d..%0d", DEPTH, MIN_DEPTH, MAX_DEPTH);
        end
    endgenerate

    // Chain tap k feeds stage k; tap 0 is the input port, tap DEPTH is the last stage output
    logic [DEPTH:0]            v_chain;
    logic [DEPTH:0][WIDTH-1:0] d_chain;

    assign v_chain[0] = in_valid;
    assign d_chain[0] = D;

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            pipe_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk       (clk),
                .rst       (rst),
                .en        (en),
                .flush     (flush),
                .in_valid  (v_chain[k]),
                .in_data   (d_chain[k]),
                .out_valid (v_chain[k+1]),
                .out_data  (d_chain[k+1])
            );
        end
    endgenerate

    assign out_valid = v_chain[DEPTH];
    assign Q         = d_chain[DEPTH];

`ifdef REGISTER_PIPE_OCC_EN
    localparam int OCC_W = occ_width(DEPTH);

    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;

    // Occupancy tracks the stage valid popcount: +1 for a word entering, -1 for the word leaving
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (en) begin
            occ_d = occ_q + OCC_W'(in_valid) - OCC_W'(v_chain[DEPTH]);
        end
    end

    // Occupancy register, cleared together with the stage valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occ = occ_q;
`endif

endmodule
